video_timing_gen: RTL and testbench

//  Parametrised raster timing generator; next generation of the fixed 320x240 counter.

---
 rtl/video_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, blanking, sync,
// display enable, line/frame strobes and a frame counter. All outputs are
// registered decodes of the next counter values, so every flag lines up with
// the hc/vc value it describes. Sync offsets are latched once per frame so
// that screen centring changes never tear a frame.
module video_timing_gen #(
    parameter int   HW       = 9,
    parameter int   VW       = 9,
    parameter int   H_ACTIVE = 320,
    parameter int   H_SS     = 350,
    parameter int   H_SE     = 370,
    parameter int   H_TOTAL  = 450,
    parameter int   V_ACTIVE = 240,
    parameter int   V_SS     = 254,
    parameter int   V_SE     = 256,
    parameter int   V_TOTAL  = 270,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [3:0]    h_offset,
    input  logic [3:0]    v_offset,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic          hbl,
    output logic          vbl,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

    // Nominal sync window edges, one bit wider than the counters so that a
    // negative offset can be added without wrapping.
    localparam logic signed [HW:0] HSS_S = (HW+1)'(H_SS);
    localparam logic signed [HW:0] HSE_S = (HW+1)'(H_SE);
    localparam logic signed [VW:0] VSS_S = (VW+1)'(V_SS);
    localparam logic signed [VW:0] VSE_S = (VW+1)'(V_SE);

    // Registered state
    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic          hbl_q, hbl_d;
    logic          vbl_q, vbl_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [3:0]    hs_off_q, hs_off_d;
    logic [3:0]    vs_off_q, vs_off_d;

    // Next-state decode helpers
    logic                 h_wrap;
    logic                 f_wrap;
    logic signed [HW:0]   hs_off_x;
    logic signed [VW:0]   vs_off_x;
    logic signed [HW:0]   hs_lo;
    logic signed [HW:0]   hs_hi;
    logic signed [VW:0]   vs_lo;
    logic signed [VW:0]   vs_hi;
    logic signed [HW:0]   hc_s;
    logic signed [VW:0]   vc_s;
    logic                 hs_act;
    logic                 vs_act;

    // Next counter values and the flags decoded from them (applied on ce).
    always_comb begin
        h_wrap = (hc_q == H_LAST);
        f_wrap = h_wrap && (vc_q == V_LAST);

        hc_d = h_wrap ? '0 : hc_q + HW'(1);
        if (!h_wrap) begin
            vc_d = vc_q;
        end else if (vc_q == V_LAST) begin
            vc_d = '0;
        end else begin
            vc_d = vc_q + VW'(1);
        end

        // Offsets are captured only when the raster re-enters (0,0); the new
        // frame's sync decode already uses the freshly captured values.
        hs_off_d = f_wrap ? h_offset : hs_off_q;
        vs_off_d = f_wrap ? v_offset : vs_off_q;

        hs_off_x = {{(HW-3){hs_off_d[3]}}, hs_off_d};
        vs_off_x = {{(VW-3){vs_off_d[3]}}, vs_off_d};
        hs_lo    = HSS_S + hs_off_x;
        hs_hi    = HSE_S + hs_off_x;
        vs_lo    = VSS_S + vs_off_x;
        vs_hi    = VSE_S + vs_off_x;
        hc_s     = $signed({1'b0, hc_d});
        vc_s     = $signed({1'b0, vc_d});
        hs_act   = (hc_s >= hs_lo) && (hc_s < hs_hi);
        vs_act   = (vc_s >= vs_lo) && (vc_s < vs_hi);

        hbl_d         = (hc_d >= H_ACT);
        vbl_d         = (vc_d >= V_ACT);
        de_d          = ~hbl_d & ~vbl_d;
        hsync_d       = hs_act ? HS_POL : ~HS_POL;
        vsync_d       = vs_act ? VS_POL : ~VS_POL;
        line_start_d  = (hc_d == '0);
        frame_start_d = f_wrap;
        frame_cnt_d   = frame_cnt_q + {7'd0, f_wrap};
    end

    // State update: reset wins over ce_pix; without ce everything holds,
    // which stretches the strobes across the whole ce period.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hbl_q         <= 1'b0;
            vbl_q         <= 1'b0;
            de_q          <= 1'b1;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
            frame_cnt_q   <= 8'd0;
            hs_off_q      <= 4'd0;
            vs_off_q      <= 4'd0;
        end else if (ce_pix) begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hbl_q         <= hbl_d;
            vbl_q         <= vbl_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            hs_off_q      <= hs_off_d;
            vs_off_q      <= vs_off_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hbl         = hbl_q;
    assign vbl         = vbl_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. Instance A uses a reduced geometry with
// active-low syncs; instance B uses the smallest legal geometry with
// active-high syncs so that 256 frames fit in a short run.
module tb_video_timing_gen;

  // Instance A geometry
  localparam int A_HW = 6, A_VW = 6;
  localparam int A_HA = 10, A_HSS = 20, A_HSE = 24, A_HT = 32;
  localparam int A_VA = 6,  A_VSS = 15, A_VSE = 17, A_VT = 25;
  // Instance B geometry
  localparam int B_HW = 5, B_VW = 5;
  localparam int B_HA = 1, B_HSS = 9, B_HSE = 10, B_HT = 18;
  localparam int B_VA = 1, B_VSS = 9, B_VSE = 10, B_VT = 18;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_a = 1'b1, ce_a = 1'b1;
  logic [3:0]      h_off_a = 4'd0, v_off_a = 4'd0;
  logic [A_HW-1:0] hc_a;
  logic [A_VW-1:0] vc_a;
  logic hbl_a, vbl_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a;
  logic [7:0]      frame_cnt_a;

  logic            reset_b = 1'b1, ce_b = 1'b1;
  logic [3:0]      h_off_b = 4'd0, v_off_b = 4'd0;
  logic [B_HW-1:0] hc_b;
  logic [B_VW-1:0] vc_b;
  logic hbl_b, vbl_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
  logic [7:0]      frame_cnt_b;

  video_timing_gen #(
    .HW(A_HW), .VW(A_VW), .H_ACTIVE(A_HA), .H_SS(A_HSS), .H_SE(A_HSE), .H_TOTAL(A_HT),
    .V_ACTIVE(A_VA), .V_SS(A_VSS), .V_SE(A_VSE), .V_TOTAL(A_VT),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset_a), .ce_pix(ce_a), .h_offset(h_off_a), .v_offset(v_off_a),
    .hc(hc_a), .vc(vc_a), .hbl(hbl_a), .vbl(vbl_a), .hsync(hsync_a), .vsync(vsync_a),
    .de(de_a), .line_start(line_start_a), .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
  );

  video_timing_gen #(
    .HW(B_HW), .VW(B_VW), .H_ACTIVE(B_HA), .H_SS(B_HSS), .H_SE(B_HSE), .H_TOTAL(B_HT),
    .V_ACTIVE(B_VA), .V_SS(B_VSS), .V_SE(B_VSE), .V_TOTAL(B_VT),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .ce_pix(ce_b), .h_offset(h_off_b), .v_offset(v_off_b),
    .hc(hc_b), .vc(vc_b), .hbl(hbl_b), .vbl(vbl_b), .hsync(hsync_b), .vsync(vsync_b),
    .de(de_b), .line_start(line_start_b), .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  // reference raster position and per-run tallies for instance A
  int ref_h, ref_v, clk_n;
  int pos_bad, flag_bad, hs_bad, vs_bad;
  int fs_rises, fs_rise_at, fs_clks, ls_cnt, de_cnt, hmax, vmax, hs_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive n_ce pixel enables on instance A, one every div clocks, and check
  // every sampled cycle against the reference position and sync windows.
  task automatic run_ce(input int n_ce, input int div, input int hs_lo, input int hs_hi,
                        input int vs_lo, input int vs_hi);
    logic fs_prev;
    logic e_hbl, e_vbl, e_hs, e_vs;
    pos_bad = 0; flag_bad = 0; hs_bad = 0; vs_bad = 0;
    fs_rises = 0; fs_rise_at = 0; fs_clks = 0; ls_cnt = 0; de_cnt = 0;
    hmax = 0; vmax = 0; hs_low = 0; clk_n = 0; fs_prev = 1'b0;
    for (int i = 0; i < n_ce; i++) begin
      for (int k = 0; k < div; k++) begin
        ce_a = (k == 0);
        step();
        clk_n++;
        if (k == 0) begin
          if (ref_h == A_HT - 1) begin
            ref_h = 0;
            ref_v = (ref_v == A_VT - 1) ? 0 : ref_v + 1;
          end else begin
            ref_h = ref_h + 1;
          end
        end
        if (32'(hc_a) !== 32'(ref_h) || 32'(vc_a) !== 32'(ref_v)) pos_bad++;
        e_hbl = (ref_h >= A_HA);
        e_vbl = (ref_v >= A_VA);
        e_hs  = (ref_h >= hs_lo && ref_h < hs_hi) ? 1'b0 : 1'b1;
        e_vs  = (ref_v >= vs_lo && ref_v < vs_hi) ? 1'b0 : 1'b1;
        if (hbl_a !== e_hbl || vbl_a !== e_vbl || de_a !== (~e_hbl & ~e_vbl) ||
            line_start_a !== (ref_h == 0) || frame_start_a !== (ref_h == 0 && ref_v == 0))
          flag_bad++;
        if (hsync_a !== e_hs) hs_bad++;
        if (vsync_a !== e_vs) vs_bad++;
        if (frame_start_a === 1'b1) begin
          fs_clks++;
          if (!fs_prev) begin
            fs_rises++;
            fs_rise_at = clk_n;
          end
        end
        fs_prev = frame_start_a;
        if (k == 0) begin
          if (line_start_a === 1'b1) ls_cnt++;
          if (de_a === 1'b1) de_cnt++;
          if (hsync_a === 1'b0) hs_low++;
        end
        if (int'(hc_a) > hmax) hmax = int'(hc_a);
        if (int'(vc_a) > vmax) vmax = int'(vc_a);
      end
    end
    ce_a = 1'b1;
  endtask

  // Instance B over many frames: sync polarity and frame counter wrap.
  int b_h, b_v, b_pos_bad, b_sync_bad, b_fc_bad, b_fs_cnt, b_hs_high;
  logic b_seen255;
  logic [7:0] b_exp_fc;
  logic [7:0] b_got;

  task automatic run_b(input int n_clk);
    b_h = 0; b_v = 0; b_pos_bad = 0; b_sync_bad = 0; b_fc_bad = 0;
    b_fs_cnt = 0; b_hs_high = 0; b_seen255 = 1'b0; b_exp_fc = 8'd0;
    for (int i = 0; i < n_clk; i++) begin
      step();
      if (b_h == B_HT - 1) begin
        b_h = 0;
        if (b_v == B_VT - 1) begin
          b_v = 0;
          b_exp_fc = b_exp_fc + 8'd1;
          exp_q.push_back(b_exp_fc);
        end else begin
          b_v = b_v + 1;
        end
      end else begin
        b_h = b_h + 1;
      end
      if (32'(hc_b) !== 32'(b_h) || 32'(vc_b) !== 32'(b_v)) b_pos_bad++;
      if (hsync_b !== (b_h == B_HSS) || vsync_b !== (b_v == B_VSS)) b_sync_bad++;
      if (hsync_b === 1'b1) b_hs_high++;
      if (frame_cnt_b === 8'd255) b_seen255 = 1'b1;
      if (frame_start_b === 1'b1) begin
        b_fs_cnt++;
        if (exp_q.size() == 0) begin
          b_fc_bad++;
        end else begin
          b_got = exp_q.pop_front();
          if (frame_cnt_b !== b_got) b_fc_bad++;
        end
      end
    end
  endtask

  initial begin
    if (A_HSS - 8 < A_HA || A_HSE + 7 > A_HT - 1 || A_VSS - 8 < A_VA || A_VSE + 7 > A_VT - 1 ||
        B_HSS - 8 < B_HA || B_HSE + 7 > B_HT - 1 || B_VSS - 8 < B_VA || B_VSE + 7 > B_VT - 1)
      $fatal(1, "geometry constraint violated");

    // reset state of A (ce held high: reset must win)
    step();
    step();
    chk("a_rst_hc", 32'(hc_a), 0);
    chk("a_rst_vc", 32'(vc_a), 0);
    chk("a_rst_hbl", 32'(hbl_a), 0);
    chk("a_rst_vbl", 32'(vbl_a), 0);
    chk("a_rst_de", 32'(de_a), 1);
    chk("a_rst_hsync", 32'(hsync_a), 1);
    chk("a_rst_vsync", 32'(vsync_a), 1);
    chk("a_rst_line_start", 32'(line_start_a), 1);
    chk("a_rst_frame_start", 32'(frame_start_a), 1);
    chk("a_rst_frame_cnt", 32'(frame_cnt_a), 0);
    reset_a = 1'b0;
    ref_h = 0; ref_v = 0;

    // one full frame at ce every clock, zero offsets
    run_ce(800, 1, 20, 24, 15, 17);
    chk("f1_pos", 32'(pos_bad), 0);
    chk("f1_flags", 32'(flag_bad), 0);
    chk("f1_hsync", 32'(hs_bad), 0);
    chk("f1_vsync", 32'(vs_bad), 0);
    chk("f1_fs_rises", 32'(fs_rises), 1);
    chk("f1_fs_rise_at", 32'(fs_rise_at), 800);
    chk("f1_line_starts", 32'(ls_cnt), 25);
    chk("f1_de_count", 32'(de_cnt), 60);
    chk("f1_hc_max", 32'(hmax), 31);
    chk("f1_vc_max", 32'(vmax), 24);
    chk("f1_hsync_low", 32'(hs_low), 100);
    chk("f1_frame_cnt", 32'(frame_cnt_a), 1);

    // ce one clock in three
    run_ce(800, 3, 20, 24, 15, 17);
    chk("ce3_pos", 32'(pos_bad), 0);
    chk("ce3_flags", 32'(flag_bad), 0);
    chk("ce3_hsync", 32'(hs_bad), 0);
    chk("ce3_vsync", 32'(vs_bad), 0);
    chk("ce3_fs_rise_at", 32'(fs_rise_at), 2398);
    chk("ce3_fs_clks", 32'(fs_clks), 3);
    chk("ce3_line_starts", 32'(ls_cnt), 25);
    chk("ce3_de_count", 32'(de_cnt), 60);
    chk("ce3_frame_cnt", 32'(frame_cnt_a), 2);

    // offsets changed at line 3: no effect until the next frame
    run_ce(96, 1, 20, 24, 15, 17);
    h_off_a = 4'b1000;
    v_off_a = 4'd7;
    run_ce(704, 1, 20, 24, 15, 17);
    chk("off_cur_hsync", 32'(hs_bad), 0);
    chk("off_cur_vsync", 32'(vs_bad), 0);
    chk("off_cur_frame_cnt", 32'(frame_cnt_a), 3);
    h_off_a = 4'd0;
    v_off_a = 4'd0;
    run_ce(800, 1, 12, 16, 22, 24);
    chk("off_next_pos", 32'(pos_bad), 0);
    chk("off_next_hsync", 32'(hs_bad), 0);
    chk("off_next_vsync", 32'(vs_bad), 0);
    chk("off_next_hsync_low", 32'(hs_low), 100);
    chk("off_next_frame_cnt", 32'(frame_cnt_a), 4);

    // mid-frame reset while both syncs are active
    run_ce(533, 1, 20, 24, 15, 17);
    chk("s5_pre_hc", 32'(hc_a), 21);
    chk("s5_pre_hsync", 32'(hsync_a), 0);
    chk("s5_pre_vsync", 32'(vsync_a), 0);
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    chk("s5_rst_hc", 32'(hc_a), 0);
    chk("s5_rst_vc", 32'(vc_a), 0);
    chk("s5_rst_frame_cnt", 32'(frame_cnt_a), 0);
    chk("s5_rst_hsync", 32'(hsync_a), 1);
    chk("s5_rst_vsync", 32'(vsync_a), 1);
    chk("s5_rst_frame_start", 32'(frame_start_a), 1);
    ref_h = 0; ref_v = 0;
    run_ce(800, 1, 20, 24, 15, 17);
    chk("s5_run_pos", 32'(pos_bad), 0);
    chk("s5_run_flags", 32'(flag_bad), 0);
    chk("s5_run_hsync", 32'(hs_bad), 0);
    chk("s5_run_fs_rises", 32'(fs_rises), 1);
    chk("s5_run_frame_cnt", 32'(frame_cnt_a), 1);

    // instance B: active-high syncs, 256 frames
    chk("b_rst_hsync", 32'(hsync_b), 0);
    chk("b_rst_vsync", 32'(vsync_b), 0);
    chk("b_rst_de", 32'(de_b), 1);
    chk("b_rst_frame_cnt", 32'(frame_cnt_b), 0);
    reset_b = 1'b0;
    run_b(256 * B_HT * B_VT);
    chk("b_pos", 32'(b_pos_bad), 0);
    chk("b_sync", 32'(b_sync_bad), 0);
    chk("b_hsync_high", 32'(b_hs_high), 256 * 18);
    chk("b_frame_starts", 32'(b_fs_cnt), 256);
    chk("b_frame_cnt_seq", 32'(b_fc_bad), 0);
    chk("b_seen_255", 32'(b_seen255), 1);
    chk("b_frame_cnt_wrap", 32'(frame_cnt_b), 0);
    chk("b_queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
